// File: rtl/tap_tempo_if.sv
// Tap-tempo bundle: enable/tap into the block, BPM result and status back out.
interface tap_tempo_if;
  logic       enable;
  logic       tap;
  logic [7:0] bpm_out;
  logic       bpm_valid;
  logic       busy;

  modport master (output enable, tap, input bpm_out, bpm_valid, busy);
  modport slave  (input enable, tap, output bpm_out, bpm_valid, busy);
endinterface

// File: rtl/tap_tempo.sv
// Tap-tempo front end: times debounced taps in ms, averages up to four intervals
// and divides 60000*k by their sum to produce a clamped 8-bit BPM.
//
//   state    | meaning
//   S_IDLE   | no tap sequence in progress, history empty
//   S_TIMING | counting ms since the last accepted tap
//   S_DIVIDE | 18-step restoring divide of 60000*k by the interval sum
module tap_tempo #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BPM_MIN    = 40,
  parameter int BPM_MAX    = 250,
  parameter int TIMEOUT_MS = 2000
) (
  input  logic       clk,
  input  logic       rst,
  tap_tempo_if.slave tt
);
  localparam int PRE_DIV = CLK_HZ / 1000;
  localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE  = PRE_W'(1);
  // The tap cycle itself counts as prescaler phase 0, so ivl reads floor(interval).
  localparam logic [PRE_W-1:0] PRE_LOAD = (PRE_DIV > 1) ? PRE_W'(1) : '0;
  localparam logic [10:0] IVL_LOAD = (PRE_DIV > 1) ? 11'd0 : 11'd1;
  localparam logic [10:0] MIN_MS   = 11'(60000 / BPM_MAX);
  localparam logic [10:0] TMO_MS   = 11'(TIMEOUT_MS);
  localparam logic [17:0] Q_MIN    = 18'(BPM_MIN);
  localparam logic [17:0] Q_MAX    = 18'(BPM_MAX);

  typedef enum logic [1:0] {S_IDLE, S_TIMING, S_DIVIDE} state_t;

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic [10:0]      ivl;
  logic [10:0]      hist [4];
  logic [2:0]       k;
  logic [17:0]      quo;
  logic [12:0]      rem;
  logic [12:0]      dvs;
  logic [4:0]       cnt;

  logic        ms_tick;
  logic [2:0]  k_new;
  logic [12:0] sum_new;
  logic [17:0] num_new;
  logic [13:0] rem_sh;
  logic        fits;
  logic [7:0]  bpm_clamped;

  always_comb begin
    ms_tick = (pre == PRE_LAST);
    k_new   = (k >= 3'd4) ? 3'd4 : k + 3'd1;
    sum_new = {2'b00, ivl};
    if (k_new > 3'd1) sum_new = sum_new + {2'b00, hist[0]};
    if (k_new > 3'd2) sum_new = sum_new + {2'b00, hist[1]};
    if (k_new > 3'd3) sum_new = sum_new + {2'b00, hist[2]};
    num_new = 18'd60000 * {15'd0, k_new};
    rem_sh  = {rem, quo[17]};
    fits    = (rem_sh >= {1'b0, dvs});
    if (quo < Q_MIN)      bpm_clamped = 8'(BPM_MIN);
    else if (quo > Q_MAX) bpm_clamped = 8'(BPM_MAX);
    else                  bpm_clamped = quo[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pre          <= '0;
      ivl          <= '0;
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      k            <= '0;
      quo          <= '0;
      rem          <= '0;
      dvs          <= '0;
      cnt          <= '0;
      tt.bpm_out   <= 8'd140;
      tt.bpm_valid <= 1'b0;
      tt.busy      <= 1'b0;
    end else begin
      tt.bpm_valid <= 1'b0;
      if (state != S_IDLE) begin
        if (ms_tick) begin
          pre <= '0;
          if (ivl < TMO_MS) ivl <= ivl + 11'd1;
        end else begin
          pre <= pre + PRE_ONE;
        end
      end

      if (!tt.enable) begin
        state   <= S_IDLE;
        tt.busy <= 1'b0;
        pre     <= '0;
        ivl     <= '0;
        k       <= '0;
        for (int i = 0; i < 4; i++) hist[i] <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (tt.tap) begin
              pre   <= PRE_LOAD;
              ivl   <= IVL_LOAD;
              k     <= '0;
              state <= S_TIMING;
            end
          end
          S_TIMING: begin
            if (ivl >= TMO_MS) begin
              k <= '0;
              for (int i = 0; i < 4; i++) hist[i] <= '0;
              if (tt.tap) begin
                pre <= PRE_LOAD;
                ivl <= IVL_LOAD;
              end else begin
                pre   <= '0;
                ivl   <= '0;
                state <= S_IDLE;
              end
            end else if (tt.tap && ivl >= MIN_MS) begin
              hist[0] <= ivl;
              hist[1] <= hist[0];
              hist[2] <= hist[1];
              hist[3] <= hist[2];
              k       <= k_new;
              quo     <= num_new;
              dvs     <= sum_new;
              rem     <= '0;
              cnt     <= '0;
              pre     <= PRE_LOAD;
              ivl     <= IVL_LOAD;
              tt.busy <= 1'b1;
              state   <= S_DIVIDE;
            end
          end
          S_DIVIDE: begin
            if (cnt == 5'd18) begin
              tt.bpm_out   <= bpm_clamped;
              tt.bpm_valid <= 1'b1;
              tt.busy      <= 1'b0;
              state        <= S_TIMING;
            end else begin
              rem <= fits ? (rem_sh[12:0] - dvs) : rem_sh[12:0];
              quo <= {quo[16:0], fits};
              cnt <= cnt + 5'd1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_tap_tempo.sv
// Self-checking bench for tap_tempo at 10 cycles per ms: fixed tap scenarios
// plus random tap trains checked against an interval-queue reference model.
module tb_tap_tempo;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  tap_tempo_if bus ();

  tap_tempo #(
    .CLK_HZ(10000), .BPM_MIN(40), .BPM_MAX(250), .TIMEOUT_MS(2000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tt (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: tap times in cycles, intervals in whole ms.
  bit m_active;
  int m_last;
  int m_q[$];
  int m_bpm;

  // Results of the most recent press().
  bit         p_acc;
  int         p_exp;
  int         p_nv;
  int         p_lat;
  int         p_nb;
  logic [7:0] p_val;

  int chain_base;

  function automatic void model_clear();
    m_active = 1'b0;
    m_q.delete();
  endfunction

  function automatic void model_tap(input int t, output bit acc, output int exp_bpm);
    int el;
    int sum;
    el = (t - m_last) / 10;
    acc = 1'b0;
    exp_bpm = m_bpm;
    if (!m_active || el >= 2000) begin
      m_active = 1'b1;
      m_last = t;
      m_q.delete();
    end else if (el >= 240) begin
      m_q.push_back(el);
      if (m_q.size() > 4) void'(m_q.pop_front());
      sum = 0;
      foreach (m_q[i]) sum += m_q[i];
      exp_bpm = (60000 * m_q.size()) / sum;
      if (exp_bpm < 40) exp_bpm = 40;
      if (exp_bpm > 250) exp_bpm = 250;
      m_bpm = exp_bpm;
      m_last = t;
      acc = 1'b1;
    end
  endfunction

  task automatic tap_at(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
    bus.tap = 1'b1;
    @(posedge clk); #1;
    bus.tap = 1'b0;
  endtask

  task automatic press(input int c);
    tap_at(c);
    model_tap(c, p_acc, p_exp);
    p_nv = 0; p_lat = -1; p_nb = 0; p_val = '0;
    while (cyc <= c + 40) begin
      if (bus.bpm_valid) begin
        p_nv++;
        if (p_lat < 0) begin
          p_lat = cyc - c;
          p_val = bus.bpm_out;
        end
      end
      if (bus.busy) p_nb++;
      @(posedge clk); #1;
    end
  endtask

  task automatic restart();
    bus.enable = 1'b0;
    @(posedge clk); #1;
    bus.enable = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus.bpm_out !== 8'd140) begin bad++; $display("FAIL reset_bpm: got %0d want 140", bus.bpm_out); end
    total++;
    if (bus.bpm_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", bus.bpm_valid); end
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    rst = 1'b0;
    m_bpm = 140;
    model_clear();
    press(cyc + 5);
    total++;
    if (p_nv !== 0 || p_nb !== 0) begin bad++; $display("FAIL reset_first_tap: valid=%0d busy_cycles=%0d want 0/0", p_nv, p_nb); end
    total++;
    if (bus.bpm_out !== 8'd140) begin bad++; $display("FAIL reset_hold: got %0d want 140", bus.bpm_out); end
  endtask

  task automatic test_averaging();
    int ms[6]   = '{0, 500, 1000, 1400, 1800, 2200};
    int want[6] = '{-1, 120, 120, 128, 133, 141};
    restart();
    chain_base = cyc + 10;
    for (int i = 0; i < 6; i++) begin
      press(chain_base + ms[i] * 10);
      total++;
      if (want[i] < 0) begin
        if (p_nv !== 0) begin bad++; $display("FAIL avg[%0d]: valid=%0d want none", i, p_nv); end
      end else if (p_nv !== 1 || p_lat !== 20 || p_nb !== 19 || p_val !== 8'(want[i])) begin
        bad++;
        $display("FAIL avg[%0d]: valid=%0d lat=%0d busy=%0d bpm=%0d want 1/20/19/%0d", i, p_nv, p_lat, p_nb, p_val, want[i]);
      end
    end
  endtask

  task automatic test_timeout();
    int nv = 0;
    while (cyc < chain_base + 42010) begin
      if (bus.bpm_valid) nv++;
      @(posedge clk); #1;
    end
    total++;
    if (nv !== 0 || bus.busy !== 1'b0) begin bad++; $display("FAIL timeout_quiet: valid=%0d busy=%b want 0/0", nv, bus.busy); end
    total++;
    if (bus.bpm_out !== 8'd141) begin bad++; $display("FAIL timeout_hold: got %0d want 141", bus.bpm_out); end
    press(chain_base + 47000);
    total++;
    if (p_nv !== 0) begin bad++; $display("FAIL timeout_first_tap: valid=%0d want none", p_nv); end
  endtask

  task automatic test_bounce();
    int ms[3]   = '{4800, 5200, 5400};
    int want[3] = '{-1, 120, -1};
    for (int i = 0; i < 3; i++) begin
      press(chain_base + ms[i] * 10);
      total++;
      if (want[i] < 0) begin
        if (p_nv !== 0 || p_nb !== 0) begin bad++; $display("FAIL bounce[%0d]: valid=%0d busy=%0d want none", i, p_nv, p_nb); end
      end else if (p_nv !== 1 || p_lat !== 20 || p_val !== 8'(want[i])) begin
        bad++;
        $display("FAIL bounce[%0d]: valid=%0d lat=%0d bpm=%0d want 1/20/%0d", i, p_nv, p_lat, p_val, want[i]);
      end
    end
  endtask

  task automatic test_clamp();
    int gap[2]  = '{18000, 2400};
    int want[2] = '{40, 250};
    int b;
    for (int i = 0; i < 2; i++) begin
      restart();
      b = cyc + 10;
      press(b);
      total++;
      if (p_nv !== 0) begin bad++; $display("FAIL clamp_first[%0d]: valid=%0d want none", i, p_nv); end
      press(b + gap[i]);
      total++;
      if (p_nv !== 1 || p_lat !== 20 || p_val !== 8'(want[i])) begin
        bad++;
        $display("FAIL clamp[%0d]: valid=%0d lat=%0d bpm=%0d want 1/20/%0d", i, p_nv, p_lat, p_val, want[i]);
      end
    end
  endtask

  task automatic test_random();
    int gap;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 2) == 0) gap = int'($urandom_range(300, 2300));
      else                           gap = int'($urandom_range(2400, 3000));
      press(cyc + gap);
      total++;
      if (p_acc ? (p_nv !== 1 || p_lat !== 20 || p_nb !== 19 || p_val !== 8'(p_exp))
                : (p_nv !== 0 || p_nb !== 0)) begin
        bad++;
        $display("FAIL rand[%0d] gap=%0d: valid=%0d lat=%0d busy=%0d bpm=%0d want accepted=%0d bpm=%0d",
                 i, gap, p_nv, p_lat, p_nb, p_val, p_acc, p_exp);
      end
      total++;
      if (bus.bpm_out !== 8'(m_bpm)) begin bad++; $display("FAIL rand_hold[%0d]: got %0d want %0d", i, bus.bpm_out, m_bpm); end
    end
  endtask

  task automatic test_abort();
    int t;
    int nv = 0;
    logic b4 = 1'b0;
    logic b7 = 1'b1;
    t = cyc + int'($urandom_range(2400, 3000));
    tap_at(t);
    while (cyc <= t + 40) begin
      if (bus.bpm_valid) nv++;
      if (cyc == t + 4) b4 = bus.busy;
      if (cyc == t + 5) bus.enable = 1'b0;
      if (cyc == t + 7) b7 = bus.busy;
      @(posedge clk); #1;
    end
    bus.enable = 1'b1;
    model_clear();
    total++;
    if (b4 !== 1'b1) begin bad++; $display("FAIL abort_busy_before: got %b want 1", b4); end
    total++;
    if (b7 !== 1'b0) begin bad++; $display("FAIL abort_busy_after: got %b want 0", b7); end
    total++;
    if (nv !== 0) begin bad++; $display("FAIL abort_valid: got %0d pulses want 0", nv); end
    total++;
    if (bus.bpm_out !== 8'(m_bpm)) begin bad++; $display("FAIL abort_hold: got %0d want %0d", bus.bpm_out, m_bpm); end
  endtask

  task automatic test_abort_reset();
    int b;
    int t;
    int nv = 0;
    logic       b4 = 1'b0;
    logic       b7 = 1'b1;
    logic [7:0] v6 = '0;
    b = cyc + 10;
    press(b);
    t = b + 2400 + int'($urandom_range(0, 600));
    tap_at(t);
    while (cyc <= t + 40) begin
      if (bus.bpm_valid) nv++;
      if (cyc == t + 4) b4 = bus.busy;
      if (cyc == t + 5) rst = 1'b1;
      if (cyc == t + 6) begin
        v6 = bus.bpm_out;
        rst = 1'b0;
      end
      if (cyc == t + 7) b7 = bus.busy;
      @(posedge clk); #1;
    end
    m_bpm = 140;
    model_clear();
    total++;
    if (b4 !== 1'b1) begin bad++; $display("FAIL rstabort_busy_before: got %b want 1", b4); end
    total++;
    if (v6 !== 8'd140) begin bad++; $display("FAIL rstabort_bpm_next: got %0d want 140", v6); end
    total++;
    if (b7 !== 1'b0) begin bad++; $display("FAIL rstabort_busy_after: got %b want 0", b7); end
    total++;
    if (nv !== 0) begin bad++; $display("FAIL rstabort_valid: got %0d pulses want 0", nv); end
    total++;
    if (bus.bpm_out !== 8'd140) begin bad++; $display("FAIL rstabort_bpm: got %0d want 140", bus.bpm_out); end
  endtask

  initial begin
    rst = 1'b1;
    bus.enable = 1'b1;
    bus.tap = 1'b0;
    m_last = 0;
    m_bpm = 140;
    model_clear();
    test_reset();
    test_averaging();
    test_timeout();
    test_bounce();
    test_clamp();
    test_random();
    test_abort();
    test_abort_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at cycle %0d, want finished", cyc);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end
endmodule
